tlm_hvl2hdl_arbiter: RTL and testbench
======================================

// Module: tlm_hvl2hdl_arbiter
// PURPOSE
// Round-robin arbiter merging Tnch ready/valid producer streams (each a
// tlm_hvl2hdl_fifo output) onto one registered ready/valid stream. A channel
// keeps its grant for up to Tburst beats, then the grant rotates. Sits between
// the per-channel HVL->HDL FIFOs and the single DUT-side consumer.
// PARAMETERS
// Tnch    4   number of requester channels (2..16)
// Twidth  32  data width per beat
// Tburst  4   max consecutive beats per grant (1..255)
// PORTS
// clock      in   1             sole clock; all logic on posedge
// reset_n    in   1             reset, asynchronous and active-low
// chan_en    in   Tnch          per-channel enable mask; 0 = never granted
// req_valid  in   Tnch          per-channel beat valid
// req_ready  out  Tnch          per-channel beat accept (combinational)
// req_data   in   Tnch*Twidth   channel i at [i*Twidth +: Twidth]
// out_valid  out  1             merged beat valid (registered)
// out_ready  in   1             consumer accept
// out_data   out  Twidth        merged beat data (registered)
// out_chan   out  $clog2(Tnch)  source channel of out_data (registered)
// BEHAVIOUR
// Clock/reset: one clock; reset is asynchronous and active-low.
// Reset values: out_valid=0, out_data=0, out_chan=0, req_ready=0,
//   state=IDLE, grant=0, burst_cnt=0, last=Tnch-1 (channel 0 wins first).
// Output register: slot_free = !out_valid || out_ready. On out_valid&&out_ready
//   with no new load, out_valid clears next cycle. out_data/out_chan stable
//   while out_valid && !out_ready.
// req_ready[i] = (state==HOLD) && (grant==i) && slot_free; 0 for all others.
// Input transfer: req_valid[grant] && req_ready[grant] -> next cycle
//   out_valid=1, out_data=req_data[grant], out_chan=grant. Latency 1 cycle.
// FSM:
//   IDLE: cand = req_valid & chan_en. If cand!=0: grant = first set bit
//     searching last+1, last+2, ... modulo Tnch (wrap); burst_cnt=0; ->HOLD.
//     Else stay. Selection costs one cycle (no transfer in IDLE).
//   HOLD: on transfer burst_cnt++; if transfer && burst_cnt==Tburst-1
//     -> IDLE, last=grant. If slot_free && !req_valid[grant] -> IDLE,
//     last=grant, no beat taken. If chan_en[grant] drops -> IDLE
//     at next edge, last=grant; a same-cycle transfer still completes.
//   Backpressure (!slot_free) holds HOLD indefinitely; burst_cnt frozen.
// Boundaries: Tburst=1 -> one beat per grant, strict rotation. Only one
//   eligible channel -> it is re-granted after its IDLE bubble. chan_en=0
//   -> no grants, in-flight out beat still drains. Reset mid-burst drops
//   out beat and grant immediately (async), restarts at channel 0.
// Peak throughput: Tburst beats per Tburst+1 cycles.
// TESTING
// T1 reset: reset_n=0 mid-transfer -> out_valid=0, req_ready=0 same cycle;
//   after release, first grant goes to ch0 when all valid.
// T2 rotation: Tnch=4, Tburst=4, all chans stream ch*0x100+n, out_ready=1
//   -> out_chan order 0,0,0,0,1,1,1,1,2..3,0; one bubble per switch.
// T3 early release: ch1 offers 2 beats then drops valid, ch2 valid ->
//   ch1 beats 0x101,0x102 then grant to ch2; last=1.
// T4 backpressure: out_ready=0 for 10 cycles during ch0 burst -> out_data
//   held, req_ready[0]=0, no beat lost or duplicated; 20 beats in = 20 out.
// T5 mask: chan_en=4'b1010, all valid -> only ch1,ch3 appear, alternating.
// T6 Tburst=1, ch0/ch3 valid -> out_chan 0,3,0,3; wrap 3->0 verified.

Source files
------------

// File: rtl/tlm_hvl2hdl_arbiter.sv
// Round-robin arbiter: merges Tnch ready/valid producer streams onto one
// registered ready/valid output, granting each channel up to Tburst beats.
module tlm_hvl2hdl_arbiter #(
    parameter int Tnch   = 4,
    parameter int Twidth = 32,
    parameter int Tburst = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [Tnch-1:0]         chan_en,
    input  logic [Tnch-1:0]         req_valid,
    output logic [Tnch-1:0]         req_ready,
    input  logic [Tnch*Twidth-1:0]  req_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Twidth-1:0]       out_data,
    output logic [$clog2(Tnch)-1:0] out_chan
);

    localparam int CHW  = $clog2(Tnch);
    localparam int CNTW = $clog2(Tburst + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            r_state;
    logic [CHW-1:0]    r_grant;
    logic [CHW-1:0]    r_last;
    logic [CNTW-1:0]   r_burst_cnt;
    logic              r_out_valid;
    logic [Twidth-1:0] r_out_data;
    logic [CHW-1:0]    r_out_chan;

    state_t            w_next_state;
    logic [CHW-1:0]    w_next_grant;
    logic [CHW-1:0]    w_next_last;
    logic [CNTW-1:0]   w_next_cnt;
    logic              w_slot_free;
    logic              w_xfer;
    logic              w_burst_end;
    logic [Tnch-1:0]   w_cand;
    logic              w_found;
    logic [CHW-1:0]    w_pick;
    logic [CHW-1:0]    w_idx;
    logic [Twidth-1:0] w_sel_data;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_cand      = req_valid & chan_en;
    assign w_xfer      = (r_state == HOLD) && w_slot_free && req_valid[r_grant];
    assign w_burst_end = w_xfer && (r_burst_cnt == CNTW'(Tburst - 1));
    assign w_sel_data  = req_data[int'(r_grant)*Twidth +: Twidth];

    // Search starts just after the last served channel, so the previous owner
    // is considered only after every other eligible channel.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= Tnch; k++) begin
            w_idx = CHW'((int'(r_last) + k) % Tnch);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last;
        w_next_cnt   = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = HOLD;
                    w_next_grant = w_pick;
                    w_next_cnt   = '0;
                end
            end
            HOLD: begin
                if (w_xfer) begin
                    w_next_cnt = r_burst_cnt + 1'b1;
                end
                // A disabled owner is dropped even under backpressure.
                if (w_burst_end || (w_slot_free && !req_valid[r_grant]) ||
                    !chan_en[r_grant]) begin
                    w_next_state = IDLE;
                    w_next_last  = r_grant;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((r_state == HOLD) && w_slot_free) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= CHW'(Tnch - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_grant     <= w_next_grant;
            r_last      <= w_next_last;
            r_burst_cnt <= w_next_cnt;
        end
    end

    // Output slot: loads on a transfer, empties when consumed, holds otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= r_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_tlm_hvl2hdl_arbiter.sv
// Bench for tlm_hvl2hdl_arbiter: two instances (Tburst=4 and Tburst=1) share
// stimulus; a behavioural model checks both every cycle, plus literal checks.
module tb_tlm_hvl2hdl_arbiter;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int CW  = 2;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b0;
    logic [NCH-1:0]  chan_en;
    logic [NCH-1:0]  req_valid;
    logic [NCH*W-1:0] req_data;
    logic            out_ready;
    logic [NCH-1:0]  req_ready_a, req_ready_b;
    logic            out_valid_a, out_valid_b;
    logic [W-1:0]    out_data_a, out_data_b;
    logic [CW-1:0]   out_chan_a, out_chan_b;

    always #5 clock = ~clock;

    tlm_hvl2hdl_arbiter #(.Tnch(NCH), .Twidth(W), .Tburst(4)) u_a (
        .clock(clock), .reset_n(reset_n), .chan_en(chan_en),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_data(req_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_chan(out_chan_a)
    );

    tlm_hvl2hdl_arbiter #(.Tnch(NCH), .Twidth(W), .Tburst(1)) u_b (
        .clock(clock), .reset_n(reset_n), .chan_en(chan_en),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_data(req_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_chan(out_chan_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Producers: channel c sends c*0x100 + cnt[c]; rem[c] beats remain.
    logic [NCH-1:0] src_mask  = '0;
    logic [NCH-1:0] gate      = '1;
    logic [NCH-1:0] pend_xfer = '0;
    int             rem[NCH];
    int             cnt[NCH];
    bit             rnd_mode  = 1'b0;

    logic [CW-1:0] qa_chan[$];
    logic [W-1:0]  qa_data[$];
    logic [CW-1:0] qb_chan[$];

    task automatic apply_inputs();
        for (int c = 0; c < NCH; c++) begin
            req_valid[c]        = src_mask[c] && gate[c] && (rem[c] > 0);
            req_data[c*W +: W]  = c * 256 + cnt[c];
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (pend_xfer[c]) begin
                cnt[c]++;
                rem[c]--;
            end
            if (rnd_mode) gate[c] = ($urandom_range(0, 3) != 0);
        end
        apply_inputs();
    endtask

    task automatic start_phase(input logic [NCH-1:0] en, input logic [NCH-1:0] mask,
                               input int lim);
        reset_n   = 1'b0;
        chan_en   = en;
        src_mask  = mask;
        gate      = '1;
        out_ready = 1'b1;
        rnd_mode  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rem[c] = lim;
            cnt[c] = 1;
        end
        apply_inputs();
        cycle();
        cycle();
        qa_chan.delete();
        qa_data.delete();
        qb_chan.delete();
        reset_n = 1'b1;
    endtask

    // Behavioural model: one entry per instance.
    int           m_burst[2] = '{4, 1};
    bit           m_hold[2];
    int           m_grant[2];
    int           m_cnt[2];
    int           m_last[2];
    bit           m_ov[2];
    logic [W-1:0] m_od[2];
    int           m_oc[2];

    function automatic void model_reset(input int k);
        m_hold[k]  = 1'b0;
        m_grant[k] = 0;
        m_cnt[k]   = 0;
        m_last[k]  = NCH - 1;
        m_ov[k]    = 1'b0;
        m_od[k]    = '0;
        m_oc[k]    = 0;
    endfunction

    function automatic logic [NCH-1:0] model_ready(input int k);
        logic [NCH-1:0] r;
        r = '0;
        if (m_hold[k] && (!m_ov[k] || out_ready)) r[m_grant[k]] = 1'b1;
        return r;
    endfunction

    function automatic void model_step(input int k);
        bit free;
        bit xfer;
        int g;
        free = !m_ov[k] || out_ready;
        g    = m_grant[k];
        xfer = m_hold[k] && free && req_valid[g];
        if (xfer) begin
            m_ov[k] = 1'b1;
            m_od[k] = req_data[g*W +: W];
            m_oc[k] = g;
        end else if (out_ready) begin
            m_ov[k] = 1'b0;
        end
        if (!m_hold[k]) begin
            for (int s = 1; s <= NCH; s++) begin
                int c;
                c = (m_last[k] + s) % NCH;
                if (req_valid[c] && chan_en[c]) begin
                    m_grant[k] = c;
                    m_hold[k]  = 1'b1;
                    m_cnt[k]   = 0;
                    break;
                end
            end
        end else begin
            if (xfer) m_cnt[k]++;
            if ((xfer && m_cnt[k] == m_burst[k]) || (free && !req_valid[g]) || !chan_en[g]) begin
                m_hold[k] = 1'b0;
                m_last[k] = g;
            end
        end
    endfunction

    task automatic cmp(input int k, input logic ov, input logic [W-1:0] od,
                       input logic [CW-1:0] oc, input logic [NCH-1:0] rr);
        check($sformatf("dut%0d_out_valid", k), ov, m_ov[k]);
        check($sformatf("dut%0d_req_ready", k), rr, model_ready(k));
        if (m_ov[k]) begin
            check($sformatf("dut%0d_out_data", k), od, m_od[k]);
            check($sformatf("dut%0d_out_chan", k), oc, m_oc[k]);
        end
    endtask

    // Compare process: inputs and DUT state are stable at the falling edge.
    always @(negedge clock) begin
        pend_xfer = req_valid & req_ready_a;
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end
        cmp(0, out_valid_a, out_data_a, out_chan_a, req_ready_a);
        cmp(1, out_valid_b, out_data_b, out_chan_b, req_ready_b);
        if (out_valid_a && out_ready) begin
            qa_chan.push_back(out_chan_a);
            qa_data.push_back(out_data_a);
        end
        if (out_valid_b && out_ready) qb_chan.push_back(out_chan_b);
        if (reset_n) begin
            model_step(0);
            model_step(1);
        end
    end

    initial begin
        chan_en   = '1;
        out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            rem[c] = 0;
            cnt[c] = 1;
        end
        apply_inputs();

        // Rotation: all channels streaming, four beats per grant, one bubble.
        start_phase(4'b1111, 4'b1111, 1000);
        check("t2_reset_valid", out_valid_a, 1'b0);
        check("t2_reset_data", out_data_a, 32'h0);
        repeat (30) cycle();
        check("t2_beat_count", qa_chan.size(), 23);
        for (int i = 0; i < 17; i++) begin
            if (i < qa_chan.size()) begin
                check($sformatf("t2_chan[%0d]", i), qa_chan[i], (i / 4) % 4);
                check($sformatf("t2_data[%0d]", i), qa_data[i],
                      ((i / 4) % 4) * 256 + (i / 16) * 4 + (i % 4) + 1);
            end
        end

        // Asynchronous reset with a beat in the output slot.
        check("t1_pre_valid", out_valid_a, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t1_valid_a", out_valid_a, 1'b0);
        check("t1_valid_b", out_valid_b, 1'b0);
        check("t1_ready_a", req_ready_a, 4'b0000);
        check("t1_data_a", out_data_a, 32'h0);
        check("t1_chan_a", out_chan_a, 2'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        check("t1_first_grant_a", req_ready_a, 4'b0001);
        check("t1_first_grant_b", req_ready_b, 4'b0001);

        // Early release: ch1 offers two beats, then ch2 takes over.
        start_phase(4'b1111, 4'b0110, 1000);
        rem[1] = 2;
        apply_inputs();
        repeat (12) cycle();
        check("t3_count_ok", qa_chan.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < qa_chan.size()) begin
                check($sformatf("t3_chan[%0d]", i), qa_chan[i], (i < 2) ? 1 : 2);
                check($sformatf("t3_data[%0d]", i), qa_data[i],
                      (i < 2) ? 32'h101 + i : 32'h201 + (i - 2));
            end
        end

        // Backpressure: 20 beats from ch0, output stalled mid-burst.
        start_phase(4'b1111, 4'b0001, 20);
        repeat (3) cycle();
        out_ready = 1'b0;
        check("t4_stall_valid", out_valid_a, 1'b1);
        check("t4_stall_data", out_data_a, 32'h2);
        repeat (10) begin
            cycle();
            check("t4_stall_ready", req_ready_a, 4'b0000);
        end
        check("t4_held_data", out_data_a, 32'h2);
        out_ready = 1'b1;
        repeat (45) cycle();
        check("t4_beat_count", qa_data.size(), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < qa_data.size()) check($sformatf("t4_data[%0d]", i), qa_data[i], i + 1);
        end

        // Channel mask: only ch1 and ch3 may be granted.
        start_phase(4'b1010, 4'b1111, 1000);
        repeat (20) cycle();
        check("t5_count_ok", qa_chan.size() >= 12, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i < qa_chan.size()) begin
                check($sformatf("t5_chan[%0d]", i), qa_chan[i], ((i / 4) % 2) ? 3 : 1);
                check($sformatf("t5_data[%0d]", i), qa_data[i],
                      (((i / 4) % 2) ? 3 : 1) * 256 + (i / 8) * 4 + (i % 4) + 1);
            end
        end

        // Single-beat grants: ch0/ch3 alternate, wrap 3 -> 0.
        start_phase(4'b1111, 4'b1001, 1000);
        repeat (20) cycle();
        check("t6_count_ok", qb_chan.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < qb_chan.size()) check($sformatf("t6_chan_b[%0d]", i), qb_chan[i], (i % 2) ? 3 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < qa_chan.size()) check($sformatf("t6_chan_a[%0d]", i), qa_chan[i], ((i / 4) % 2) ? 3 : 0);
        end

        // Random traffic, enables and backpressure; model checks every cycle.
        start_phase(4'b1111, 4'b1111, 1 << 30);
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) chan_en = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) chan_en = 4'b1111;
            if (i == 1500) begin
                reset_n = 1'b0;
                cycle();
                reset_n = 1'b1;
            end
        end
        check("rnd_beats_seen", qa_chan.size() > 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
